// File: rtl/mtr_cmd_ramp_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mtr_cmd_ramp_if                                                 |
// | Purpose  : Command handshake bundle between the steering/command logic and |
// |            the motor slew-rate limiter.                                    |
// | Signals  : cmd_vld  - target pair valid (master -> slave)                  |
// |            cmd_rdy  - slave can accept a target pair (slave -> master)     |
// |            cmd_lft  - signed 11-bit left target                            |
// |            cmd_rht  - signed 11-bit right target                           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface mtr_cmd_ramp_if;
   logic        cmd_vld;
   logic        cmd_rdy;
   logic [10:0] cmd_lft;
   logic [10:0] cmd_rht;

   modport master (output cmd_vld, output cmd_lft, output cmd_rht, input  cmd_rdy);
   modport slave  (input  cmd_vld, input  cmd_lft, input  cmd_rht, output cmd_rdy);
endinterface
`default_nettype wire

// File: rtl/mtr_cmd_ramp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mtr_cmd_ramp                                                    |
// | Purpose  : Slew-rate limiter and reversal guard ahead of motor_cntrl.      |
// |            Each channel ramps toward its target by STEP per tick; a sign   |
// |            reversal first ramps to zero and dwells DWELL_TICKS ticks.      |
// | Ports    : clk      - system clock                                         |
// |            rst      - synchronous active-high reset                        |
// |            cmd_if   - command handshake (slave modport)                    |
// |            estop_i  - emergency brake, level-sensitive                     |
// |            lft_o    - signed left drive, registered                        |
// |            rht_o    - signed right drive, registered                       |
// |            at_tgt_o - both channels settled on their targets, registered   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module mtr_cmd_ramp #(
   parameter int STEP        = 8,
   parameter int TICK_DIV    = 16,
   parameter int DWELL_TICKS = 4
) (
   input  logic               clk,
   input  logic               rst,
   mtr_cmd_ramp_if.slave      cmd_if,
   input  logic               estop_i,
   output logic signed [10:0] lft_o,
   output logic signed [10:0] rht_o,
   output logic               at_tgt_o
);

   localparam int c_CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int c_DW_W  = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
   localparam logic signed [11:0] c_STEP = $signed(12'(STEP));

   localparam logic [1:0] c_HOLD  = 2'd0;
   localparam logic [1:0] c_RAMP  = 2'd1;
   localparam logic [1:0] c_DWELL = 2'd2;

   function automatic logic signed [10:0] f_sat(input logic signed [11:0] x);
      if (x > 12'sd1023)
         f_sat = 11'sd1023;
      else if (x < -12'sd1023)
         f_sat = -11'sd1023;
      else
         f_sat = x[10:0];
   endfunction

   // Tick generator: free-running divider, tick on the terminal count.
   logic [c_CNT_W-1:0] tick_cnt_q;
   logic               w_tick;

   assign w_tick = (tick_cnt_q == c_CNT_W'(TICK_DIV - 1));

   always_ff @(posedge clk) begin
      if (rst || w_tick)
         tick_cnt_q <= '0;
      else
         tick_cnt_q <= tick_cnt_q + c_CNT_W'(1);
   end

   // Ready is a registered copy of !estop so it drops one edge after estop.
   logic cmd_rdy_q;
   logic w_accept;

   always_ff @(posedge clk) begin
      if (rst)
         cmd_rdy_q <= 1'b0;
      else
         cmd_rdy_q <= ~estop_i;
   end

   assign cmd_if.cmd_rdy = cmd_rdy_q;
   assign w_accept       = cmd_if.cmd_vld & cmd_rdy_q & ~estop_i;

   logic [10:0] w_cmd [2];
   assign w_cmd[0] = cmd_if.cmd_lft;
   assign w_cmd[1] = cmd_if.cmd_rht;

   for (genvar g = 0; g < 2; g++) begin : g_ch
      logic signed [10:0] out_q, out_d;
      logic signed [10:0] tgt_q, tgt_d;
      logic [1:0]         st_q, st_d;
      logic [c_DW_W-1:0]  dwell_q, dwell_d;
      logic signed [10:0] w_cap, w_step;
      logic signed [11:0] w_out12, w_goal12, w_diff;
      logic               w_rev, w_done;

      // -1024 has no positive counterpart; clamp to keep the range symmetric.
      assign w_cap = (w_cmd[g] == 11'h400) ? 11'h401 : w_cmd[g];

      // Opposite non-zero signs: head for zero first.
      assign w_rev    = (out_q != 11'sd0) && (tgt_q != 11'sd0) && (out_q[10] != tgt_q[10]);
      assign w_out12  = {out_q[10], out_q};
      assign w_goal12 = w_rev ? 12'sd0 : {tgt_q[10], tgt_q};
      assign w_diff   = w_goal12 - w_out12;
      assign w_done   = (st_q == c_HOLD) && (out_q == tgt_q);

      // One bounded step toward the goal; the final step lands exactly on it.
      always_comb begin
         w_step = w_goal12[10:0];
         if (w_diff > c_STEP)
            w_step = f_sat(w_out12 + c_STEP);
         else if (w_diff < -c_STEP)
            w_step = f_sat(w_out12 - c_STEP);
      end

      always_comb begin
         out_d   = out_q;
         tgt_d   = tgt_q;
         st_d    = st_q;
         dwell_d = dwell_q;
         case (st_q)
            c_HOLD: begin
               if (out_q != tgt_q)
                  st_d = c_RAMP;
            end
            c_RAMP: begin
               if (out_q == tgt_q)
                  st_d = c_HOLD;
               else if (w_tick) begin
                  out_d = w_step;
                  if (w_step == tgt_q)
                     st_d = c_HOLD;
                  else if (w_rev && (w_step == 11'sd0)) begin
                     st_d    = c_DWELL;
                     dwell_d = '0;
                  end
               end
            end
            c_DWELL: begin
               // Dwell ignores target changes; the target is only consulted at the end.
               if (w_tick) begin
                  if (dwell_q == c_DW_W'(DWELL_TICKS - 1)) begin
                     dwell_d = '0;
                     st_d    = (tgt_q == 11'sd0) ? c_HOLD : c_RAMP;
                  end else begin
                     dwell_d = dwell_q + c_DW_W'(1);
                  end
               end
            end
            default: st_d = c_HOLD;
         endcase
         // Captured target is only seen by the step logic from the next cycle on.
         if (w_accept)
            tgt_d = w_cap;
         if (estop_i) begin
            out_d   = '0;
            tgt_d   = '0;
            st_d    = c_HOLD;
            dwell_d = '0;
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            out_q   <= '0;
            tgt_q   <= '0;
            st_q    <= c_HOLD;
            dwell_q <= '0;
         end else begin
            out_q   <= out_d;
            tgt_q   <= tgt_d;
            st_q    <= st_d;
            dwell_q <= dwell_d;
         end
      end
   end

   logic at_tgt_q;

   always_ff @(posedge clk) begin
      if (rst)
         at_tgt_q <= 1'b1;
      else
         at_tgt_q <= g_ch[0].w_done & g_ch[1].w_done;
   end

   assign lft_o    = g_ch[0].out_q;
   assign rht_o    = g_ch[1].out_q;
   assign at_tgt_o = at_tgt_q;

endmodule
`default_nettype wire

// File: tb/tb_mtr_cmd_ramp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mtr_cmd_ramp                                                 |
// | Purpose  : Directed self-checking bench for mtr_cmd_ramp (STEP=8,          |
// |            TICK_DIV=16, DWELL_TICKS=4).                                    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_mtr_cmd_ramp;

   logic               clk = 1'b0;
   logic               rst;
   logic               estop;
   logic signed [10:0] lft_s;
   logic signed [10:0] rht_s;
   logic               at_tgt;
   int                 n_vec  = 0;
   int                 n_fail = 0;

   mtr_cmd_ramp_if cif ();

   mtr_cmd_ramp #(
      .STEP        (8),
      .TICK_DIV    (16),
      .DWELL_TICKS (4)
   ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .cmd_if   (cif),
      .estop_i  (estop),
      .lft_o    (lft_s),
      .rht_o    (rht_s),
      .at_tgt_o (at_tgt)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached before end of sequence");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input int obs, input int exp_v);
      n_vec++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic clocks(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // Called at a negedge; leaves at the negedge after the accept edge.
   task automatic send(input logic [10:0] l, input logic [10:0] r);
      int n;
      n = 0;
      cif.cmd_vld = 1'b1;
      cif.cmd_lft = l;
      cif.cmd_rht = r;
      while (!cif.cmd_rdy && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("send_rdy", int'(cif.cmd_rdy), 1);
      @(negedge clk);
      cif.cmd_vld = 1'b0;
   endtask

   // Follows n output changes on lft, each expected to be one bounded step toward goal.
   task automatic track(input string tag, input int goal, input int n,
                        input bit rfollow, input int rexp);
      int prev, expv, gap;
      prev = lft_s;
      for (int i = 0; i < n; i++) begin
         gap = 0;
         do begin
            @(negedge clk);
            gap++;
         end while (lft_s == prev && gap < 64);
         if (goal > prev)
            expv = (goal - prev > 8) ? prev + 8 : goal;
         else
            expv = (prev - goal > 8) ? prev - 8 : goal;
         chk({tag, "_val"}, lft_s, expv);
         if (i > 0)
            chk({tag, "_period"}, gap, 16);
         chk({tag, "_rht"}, rht_s, rfollow ? expv : rexp);
         prev = lft_s;
      end
   endtask

   initial begin
      int gap;
      logic [10:0] lft_bits;

      rst         = 1'b1;
      estop       = 1'b0;
      cif.cmd_vld = 1'b0;
      cif.cmd_lft = '0;
      cif.cmd_rht = '0;

      // Reset state
      clocks(10);
      chk("rst_lft", lft_s, 0);
      chk("rst_rht", rht_s, 0);
      chk("rst_rdy", int'(cif.cmd_rdy), 0);
      chk("rst_at_tgt", int'(at_tgt), 1);
      rst = 1'b0;
      @(negedge clk);
      chk("rdy_after_rst", int'(cif.cmd_rdy), 1);

      // 1: both channels ramp 0 -> 256
      send(11'h100, 11'h100);
      track("up256", 256, 32, 1'b1, 0);
      chk("up256_at_tgt_lag", int'(at_tgt), 0);
      @(negedge clk);
      chk("up256_at_tgt", int'(at_tgt), 1);

      // 2: left reverses to -256 through zero and a dwell
      send(11'h700, 11'h100);
      track("rev_down", 0, 32, 1'b0, 256);
      gap = 0;
      do begin
         @(negedge clk);
         gap++;
      end while (lft_s == 0 && gap < 200);
      chk("rev_dwell_clocks", gap, 80);
      chk("rev_first_neg", lft_s, -8);
      track("rev_neg", -256, 31, 1'b0, 256);
      clocks(2);
      chk("rev_at_tgt", int'(at_tgt), 1);

      // 5: reset in the middle of a dwell, then a fresh command
      send(11'h100, 11'h100);
      track("dw_down", 0, 32, 1'b0, 256);
      clocks(20);
      chk("dw_mid_lft", lft_s, 0);
      rst = 1'b1;
      @(negedge clk);
      chk("dw_rst_lft", lft_s, 0);
      chk("dw_rst_rht", rht_s, 0);
      chk("dw_rst_rdy", int'(cif.cmd_rdy), 0);
      chk("dw_rst_at_tgt", int'(at_tgt), 1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      send(11'h100, 11'h100);
      gap = 0;
      while (lft_s == 0 && gap < 40) begin
         @(negedge clk);
         gap++;
      end
      chk("fresh_first_step", lft_s, 8);
      chk("fresh_no_dwell", int'(gap < 40), 1);
      track("fresh", 120, 14, 1'b1, 0);

      // 4: estop at lft=120
      estop = 1'b1;
      @(negedge clk);
      chk("estop_lft", lft_s, 0);
      chk("estop_rht", rht_s, 0);
      chk("estop_rdy", int'(cif.cmd_rdy), 0);
      cif.cmd_vld = 1'b1;
      cif.cmd_lft = 11'd100;
      cif.cmd_rht = 11'd100;
      clocks(40);
      chk("estop_held_lft", lft_s, 0);
      chk("estop_held_rdy", int'(cif.cmd_rdy), 0);
      cif.cmd_vld = 1'b0;
      estop = 1'b0;
      @(negedge clk);
      chk("release_rdy", int'(cif.cmd_rdy), 1);
      clocks(40);
      chk("release_lft", lft_s, 0);
      chk("release_rht", rht_s, 0);
      chk("release_at_tgt", int'(at_tgt), 1);

      // 3: -1024 command clamps to -1023
      send(11'h400, 11'h000);
      track("clamp", -1023, 128, 1'b0, 0);
      lft_bits = lft_s;
      chk("clamp_bits", int'(lft_bits), 'h401);
      clocks(40);
      chk("clamp_hold", lft_s, -1023);
      chk("clamp_at_tgt", int'(at_tgt), 1);

      // 6: retarget mid-ramp at lft=64 from 256 down to 32
      estop = 1'b1;
      @(negedge clk);
      estop = 1'b0;
      @(negedge clk);
      send(11'h100, 11'h000);
      track("retgt_up", 64, 8, 1'b0, 0);
      send(11'h020, 11'h000);
      track("retgt_down", 32, 4, 1'b0, 0);
      clocks(3);
      chk("retgt_lft", lft_s, 32);
      chk("retgt_at_tgt", int'(at_tgt), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
